// File: rtl/clock_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_gate_ctrl_if
//   Bundles the activity inputs and the gate/handshake outputs of
//   clock_gate_ctrl. The controller sits on the slave modport. The block
//   that requests service sits on the master modport.
//
//   Signals (direction seen from the controller):
//     busy_i        in   downstream logic active, keeps clock running
//     req_i         in   wake/service request (four-phase level handshake)
//     force_on_i    in   debug override, clock never gated while high
//     en_o          out  gate enable for clock_gating.en_i
//     ack_o         out  request granted, gated clock running and settled
//     gated_o       out  1 while the clock is gated off
//     gate_count_o  out  saturating count of RUN/IDLE_WAIT -> GATED events
//     state_o       out  FSM state (debug): 0 RUN, 1 IDLE_WAIT, 2 GATED, 3 WAKE
//
//   Handshake: the requester raises req_i and holds it until ack_o is seen
//   high. It then drops req_i, and ack_o drops one edge later. Both sides
//   move one level per phase. Dropping req_i before ack_o is a protocol
//   violation. In that case ack_o simply never rises for that request.
// ---------------------------------------------------------------------------
interface clock_gate_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             busy_i;
    logic             req_i;
    logic             force_on_i;
    logic             en_o;
    logic             ack_o;
    logic             gated_o;
    logic [CNT_W-1:0] gate_count_o;
    logic [1:0]       state_o;

    modport master (
        output busy_i, req_i, force_on_i,
        input  en_o, ack_o, gated_o, gate_count_o, state_o
    );

    modport slave (
        input  busy_i, req_i, force_on_i,
        output en_o, ack_o, gated_o, gate_count_o, state_o
    );
endinterface

// File: rtl/clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clock_gate_ctrl
//   Generates the enable for a downstream clock_gating cell. The clock is
//   gated off only after IDLE_CYCLES consecutive idle edges. When activity
//   returns, the clock is re-enabled, and a request is acknowledged only
//   after a WAKE_CYCLES settle window. The block runs on the free-running
//   clock.
//
//   Ports:
//     clk_i   free-running (ungated) clock
//     rst_ni  asynchronous active-low reset. Assertion is immediate and
//             restores en_o=1. Release is synchronised to clk_i.
//     bus     clock_gate_ctrl_if.slave (see interface header for signals)
//
//   Parameters:
//     IDLE_CYCLES  idle edges before gating off (>= 1)
//     WAKE_CYCLES  settle edges after re-enable before ack (0 = none)
//     CNT_W        width of the saturating gate-event counter
// ---------------------------------------------------------------------------
module clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    clock_gate_ctrl_if.slave bus
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = (WAKE_CYCLES < 1) ? 1 : $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_e;

    // Reset synchroniser: the reset asserts asynchronously. Its release is
    // retimed to clk_i so that no flop leaves reset on an ambiguous edge.
    logic rst_meta_q;
    logic rst_sync_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_meta_q <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_n <= rst_meta_q;
        end
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [WW-1:0]    wake_q, wake_d;
    logic             en_q, gated_q, ack_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active;
    logic             gate_evt;

    assign active = bus.busy_i | bus.req_i | bus.force_on_i;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            RUN: begin
                if (!active) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = GATED;
                        idle_d  = '0;
                    end else begin
                        state_d = IDLE_WAIT;
                        idle_d  = IW'(1);
                    end
                end
            end
            IDLE_WAIT: begin
                // Activity takes priority over an expiring idle count.
                if (active) begin
                    state_d = RUN;
                    idle_d  = '0;
                end else if (idle_q + IW'(1) == IDLE_LAST) begin
                    state_d = GATED;
                    idle_d  = '0;
                end else begin
                    idle_d  = idle_q + IW'(1);
                end
            end
            GATED: begin
                if (active) begin
                    state_d = (WAKE_CYCLES == 0) ? RUN : WAKE;
                    wake_d  = '0;
                end
            end
            WAKE: begin
                // The settle window always runs to completion, even if activity drops.
                if (WAKE_CYCLES == 0 || wake_q + WW'(1) == WAKE_LAST) begin
                    state_d = RUN;
                    wake_d  = '0;
                end else begin
                    wake_d  = wake_q + WW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign gate_evt = (state_q != GATED) && (state_d == GATED);

    // The outputs are decoded from the next state and then registered, so
    // en_o changes only on a rising clk_i edge. It is therefore stable
    // through the low phase that the clock_gating latch samples.
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= RUN;
            idle_q  <= '0;
            wake_q  <= '0;
            en_q    <= 1'b1;
            gated_q <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            en_q    <= (state_d != GATED);
            gated_q <= (state_d == GATED);
            // A request held high keeps the FSM in RUN, so ack follows req only while in RUN.
            ack_q   <= bus.req_i && (state_q == RUN);
            if (gate_evt && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.en_o         = en_q;
    assign bus.gated_o      = gated_q;
    assign bus.ack_o        = ack_q;
    assign bus.gate_count_o = cnt_q;
    assign bus.state_o      = state_q;
endmodule
